// File: rtl/reg_file_sb.sv
//------------------------------------------------------------------------------
// Module      : reg_file_sb
// Description : Integer register file with two async read ports, one write-back
//               port and a per-register outstanding-write scoreboard.
//               Optional write-through bypass: define REGFILE_BYPASS_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module reg_file_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32,
    parameter int PEND_W   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs1_addr,
    output logic [DATA_W-1:0] rs1_data,
    output logic              rs1_busy,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] rs2_data,
    output logic              rs2_busy,
    input  logic              rsv_valid,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              rsv_ready,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    output logic              sb_err
);

    localparam logic [PEND_W-1:0] c_cnt_max = '1;

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [PEND_W-1:0] r_cnt  [NUM_REGS];
    logic [PEND_W-1:0] w_cnt_nxt [NUM_REGS];
    logic [NUM_REGS-1:0] w_inc;
    logic [NUM_REGS-1:0] w_dec;
    logic              r_sb_err;
    logic              w_rsv_cnt;
    logic              w_wb_hit;
    logic              w_wb_orphan;

    assign rsv_ready   = (rsv_addr == '0) || (r_cnt[rsv_addr] != c_cnt_max);
    // Reservations of x0 are accepted but never counted.
    assign w_rsv_cnt   = rsv_valid && rsv_ready && !flush && (rsv_addr != '0);
    assign w_wb_hit    = wb_valid && (wb_addr != '0);
    assign w_wb_orphan = w_wb_hit && !flush && (r_cnt[wb_addr] == '0);

    generate
        for (genvar i = 0; i < NUM_REGS; i++) begin : g_cnt
            assign w_inc[i] = w_rsv_cnt && (rsv_addr == ADDR_W'(i));
            assign w_dec[i] = w_wb_hit && (wb_addr == ADDR_W'(i)) && (r_cnt[i] != '0);
            assign w_cnt_nxt[i] = flush                  ? '0 :
                                  (w_inc[i] && !w_dec[i]) ? r_cnt[i] + PEND_W'(1) :
                                  (w_dec[i] && !w_inc[i]) ? r_cnt[i] - PEND_W'(1) :
                                                            r_cnt[i];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
                r_cnt[i]  <= '0;
            end
            r_sb_err <= 1'b0;
        end else begin
            if (w_wb_hit) begin
                r_regs[wb_addr] <= wb_data;
            end
            for (int i = 0; i < NUM_REGS; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
            if (w_wb_orphan) begin
                r_sb_err <= 1'b1;
            end
        end
    end

    always_comb begin
        rs1_data = (rs1_addr == '0) ? '0 : r_regs[rs1_addr];
        rs2_data = (rs2_addr == '0) ? '0 : r_regs[rs2_addr];
`ifdef REGFILE_BYPASS_EN
        if (w_wb_hit && (wb_addr == rs1_addr)) begin
            rs1_data = wb_data;
        end
        if (w_wb_hit && (wb_addr == rs2_addr)) begin
            rs2_data = wb_data;
        end
`endif
    end

    assign rs1_busy = (r_cnt[rs1_addr] != '0);
    assign rs2_busy = (r_cnt[rs2_addr] != '0);
    assign sb_err   = r_sb_err;

endmodule

`default_nettype wire

// File: tb/tb_reg_file_sb.sv
//------------------------------------------------------------------------------
// Module      : tb_reg_file_sb
// Description : Self-checking bench for reg_file_sb against an array-based
//               reference model; directed scenarios followed by random traffic.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_reg_file_sb;

    localparam int c_max_cnt = 3;

    logic        clk;
    logic        reset;
    logic [4:0]  rs1_addr, rs2_addr, rsv_addr, wb_addr;
    logic [31:0] rs1_data, rs2_data, wb_data;
    logic        rs1_busy, rs2_busy, rsv_valid, rsv_ready, wb_valid, flush, sb_err;

    logic [31:0] m_regs [32];
    int          m_cnt  [32];
    logic        m_err;
    int          n_checks;
    int          n_bad;

    reg_file_sb dut (
        .clk       (clk),
        .reset     (reset),
        .rs1_addr  (rs1_addr),
        .rs1_data  (rs1_data),
        .rs1_busy  (rs1_busy),
        .rs2_addr  (rs2_addr),
        .rs2_data  (rs2_data),
        .rs2_busy  (rs2_busy),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .rsv_ready (rsv_ready),
        .wb_valid  (wb_valid),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .flush     (flush),
        .sb_err    (sb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_cnt[i]  = 0;
        end
        m_err = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rsv_valid = 1'b0; wb_valid = 1'b0; flush = 1'b0;
        rsv_addr = '0; wb_addr = '0; wb_data = '0; rs1_addr = '0; rs2_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
    endtask

    // One clock: apply inputs, check outputs mid-cycle, advance the model.
    task automatic cyc(input logic rv, input logic [4:0] ra, input logic wv, input logic [4:0] wa,
                       input logic [31:0] wd, input logic fl, input logic [4:0] a1, input logic [4:0] a2);
        logic [31:0] e1, e2;
        logic        erdy;
        rsv_valid = rv; rsv_addr = ra; wb_valid = wv; wb_addr = wa; wb_data = wd;
        flush = fl; rs1_addr = a1; rs2_addr = a2;
        #4;
        e1 = (a1 == 0) ? 32'd0 : m_regs[a1];
        e2 = (a2 == 0) ? 32'd0 : m_regs[a2];
`ifdef REGFILE_BYPASS_EN
        if (wv && wa != 0 && wa == a1) e1 = wd;
        if (wv && wa != 0 && wa == a2) e2 = wd;
`endif
        erdy = (ra == 0) || (m_cnt[ra] != c_max_cnt);
        check_value("rs1_data", rs1_data, e1);
        check_value("rs2_data", rs2_data, e2);
        check_value("rs1_busy", {31'd0, rs1_busy}, {31'd0, m_cnt[a1] != 0});
        check_value("rs2_busy", {31'd0, rs2_busy}, {31'd0, m_cnt[a2] != 0});
        check_value("rsv_ready", {31'd0, rsv_ready}, {31'd0, erdy});
        check_value("sb_err", {31'd0, sb_err}, {31'd0, m_err});
        if (wv && wa != 0) begin
            m_regs[wa] = wd;
            if (!fl) begin
                if (m_cnt[wa] == 0) m_err = 1'b1;
                else m_cnt[wa]--;
            end
        end
        if (rv && erdy && !fl && ra != 0) m_cnt[ra]++;
        if (fl) begin
            for (int i = 0; i < 32; i++) m_cnt[i] = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [4:0] a1, input logic [4:0] a2);
        cyc(1'b0, a1, 1'b0, 5'd0, 32'd0, 1'b0, a1, a2);
    endtask

    initial begin
        n_checks = 0;
        n_bad    = 0;
        do_reset();

        // Reset state across all addresses.
        for (int a = 0; a < 32; a++) idle(5'(a), 5'(31 - a));

        // Plain write-back, then x0 write is dropped.
        cyc(1'b0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd5, 5'd0);
        idle(5'd5, 5'd0);
        cyc(1'b0, 5'd0, 1'b1, 5'd0, 32'hCAFEF00D, 1'b0, 5'd0, 5'd5);
        idle(5'd0, 5'd0);

        // Saturate x7, fourth reserve refused, drain with three write-backs.
        repeat (4) cyc(1'b1, 5'd7, 1'b0, 5'd0, 32'd0, 1'b0, 5'd7, 5'd7);
        for (int k = 0; k < 3; k++) cyc(1'b0, 5'd7, 1'b1, 5'd7, 32'h700 + k, 1'b0, 5'd7, 5'd6);
        idle(5'd7, 5'd7);

        // Reserve and write back x9 in one cycle with one outstanding.
        cyc(1'b1, 5'd9, 1'b0, 5'd0, 32'd0, 1'b0, 5'd9, 5'd9);
        cyc(1'b1, 5'd9, 1'b1, 5'd9, 32'h99, 1'b0, 5'd9, 5'd9);
        idle(5'd9, 5'd9);

        // Flush drops reservations and a concurrent reserve; orphan wb raises sb_err.
        cyc(1'b1, 5'd3, 1'b0, 5'd0, 32'd0, 1'b0, 5'd3, 5'd4);
        cyc(1'b1, 5'd4, 1'b0, 5'd0, 32'd0, 1'b0, 5'd3, 5'd4);
        cyc(1'b1, 5'd6, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd4);
        idle(5'd6, 5'd4);
        cyc(1'b0, 5'd0, 1'b1, 5'd3, 32'h3333, 1'b0, 5'd3, 5'd6);
        idle(5'd3, 5'd3);

        // Write-through vs. next-cycle visibility.
        cyc(1'b0, 5'd0, 1'b1, 5'd10, 32'h1234, 1'b0, 5'd10, 5'd10);
        idle(5'd10, 5'd10);

        // Random traffic, addresses biased toward a few registers to force collisions.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            logic [4:0] ra, wa, a1, a2;
            ra = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 5));
            wa = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 5));
            a1 = ($urandom_range(0, 1) == 0) ? wa : 5'($urandom_range(0, 7));
            a2 = ($urandom_range(0, 1) == 0) ? ra : 5'($urandom);
            cyc(1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 2) == 0), wa, $urandom,
                1'($urandom_range(0, 40) == 0), a1, a2);
        end

        // Reset clears sticky error and scoreboard.
        do_reset();
        for (int a = 0; a < 32; a += 4) idle(5'(a), 5'(a + 1));

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
